matrixmul_ctrl: RTL and testbench

MATRIXMUL_CTRL -- requirements
Module: matrixmul_ctrl

---
 rtl/matrixmul_ctrl.sv | 140 ++++++++++++++
 tb/tb_matrixmul_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/matrixmul_ctrl.sv
// N x N matrix multiply sequencer: streams A rows and B columns out of BRAM,
// accumulates one dot product per C element and writes it back row-major.
module matrixmul_ctrl #(
  parameter int N               = 8,
  parameter int BRAM_ADDR_WIDTH = 6,
  parameter int BRAM_DATA_WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [BRAM_ADDR_WIDTH-1:0] a_rd_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] a_dout,
  output logic [BRAM_ADDR_WIDTH-1:0] b_rd_addr,
  input  logic [BRAM_DATA_WIDTH-1:0] b_dout,
  output logic [BRAM_ADDR_WIDTH-1:0] c_wr_addr,
  output logic                       c_wr_en,
  output logic [BRAM_DATA_WIDTH-1:0] c_din
);

  // N*N == 2**BRAM_ADDR_WIDTH, so N is a power of two and row*N+col is {row, col}.
  localparam int IDX_W = BRAM_ADDR_WIDTH / 2;
  localparam int DW    = BRAM_DATA_WIDTH;

  localparam logic [IDX_W:0]   K_LAST   = (IDX_W + 1)'(N);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  row_i;
  logic [IDX_W-1:0]  col_j;
  logic [IDX_W:0]    k_cnt;
  logic [DW-1:0]     acc;
  logic              last_elem;
  logic              k_at_last;

  // Product and sum both wrap modulo 2**DW.
  function automatic logic [DW-1:0] mac_wrap(input logic [DW-1:0] sum,
                                             input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    logic [2*DW-1:0] prod;
    prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    return sum + prod[DW-1:0];
  endfunction

  assign last_elem = (row_i == IDX_LAST) && (col_j == IDX_LAST);
  assign k_at_last = (k_cnt == K_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MAC;
      MAC:     if (k_at_last) state_nxt = WRITE;
      WRITE:   state_nxt = last_elem ? DONE : MAC;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    a_rd_addr = '0;
    b_rd_addr = '0;
    c_wr_addr = '0;
    c_wr_en   = 1'b0;
    c_din     = '0;
    case (state)
      MAC: begin
        busy = 1'b1;
        if (!k_at_last) begin
          a_rd_addr = {row_i, k_cnt[IDX_W-1:0]};
          b_rd_addr = {k_cnt[IDX_W-1:0], col_j};
        end
      end
      WRITE: begin
        busy      = 1'b1;
        c_wr_en   = 1'b1;
        c_wr_addr = {row_i, col_j};
        c_din     = acc;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // BRAM data lags the address by one cycle, so k=0 only issues reads and
  // the final accumulate lands on k=N.
  always_ff @(posedge clock) begin
    if (reset) begin
      row_i <= '0;
      col_j <= '0;
      k_cnt <= '0;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row_i <= '0;
            col_j <= '0;
            k_cnt <= '0;
            acc   <= '0;
          end
        end
        MAC: begin
          if (k_cnt != '0) acc <= mac_wrap(acc, a_dout, b_dout);
          if (!k_at_last)  k_cnt <= k_cnt + 1'b1;
        end
        WRITE: begin
          k_cnt <= '0;
          acc   <= '0;
          if (col_j == IDX_LAST) begin
            col_j <= '0;
            row_i <= row_i + 1'b1;
          end else begin
            col_j <= col_j + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrixmul_ctrl.sv
// Bench for matrixmul_ctrl: BRAM models, a matrix-product reference and a
// cycle-timing model of when each read, write and done must appear.
module tb_matrixmul_ctrl;
  localparam int N    = 8;
  localparam int AW   = 6;
  localparam int DW   = 32;
  localparam int P    = N + 2;
  localparam int NE   = N * N;
  localparam int LAST = NE * P;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] a_rd_addr;
  logic [AW-1:0] b_rd_addr;
  logic [AW-1:0] c_wr_addr;
  logic [DW-1:0] a_dout;
  logic [DW-1:0] b_dout;
  logic [DW-1:0] c_din;
  logic          c_wr_en;

  logic [DW-1:0] a_mem [NE];
  logic [DW-1:0] b_mem [NE];
  logic [DW-1:0] c_mem [NE];
  logic [DW-1:0] c_ref [NE];

  int tests = 0;
  int fails = 0;
  int wr_count, done_count, done_cyc, first_wr_cyc, first_wr_addr;
  int proto_err, data_err, bad_cyc;

  matrixmul_ctrl #(.N(N), .BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .a_rd_addr(a_rd_addr), .a_dout(a_dout), .b_rd_addr(b_rd_addr), .b_dout(b_dout),
    .c_wr_addr(c_wr_addr), .c_wr_en(c_wr_en), .c_din(c_din)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    a_dout <= a_mem[a_rd_addr];
    b_dout <= b_mem[b_rd_addr];
    if (c_wr_en) c_mem[c_wr_addr] <= c_din;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compute_ref();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        logic [DW-1:0] s;
        s = '0;
        for (int k = 0; k < N; k++) s = s + a_mem[r*N+k] * b_mem[k*N+c];
        c_ref[r*N+c] = s;
      end
  endtask

  task automatic fill_random();
    for (int x = 0; x < NE; x++) begin
      a_mem[x] = $urandom;
      b_mem[x] = $urandom;
    end
  endtask

  // Cycle 0 is the cycle in which start is sampled; outputs sampled at negedge.
  task automatic run_mult(input int reset_at, input int pulse_at, input bit hold);
    int limit;
    limit = hold ? (LAST + 2) : (LAST + 20);
    wr_count = 0; done_count = 0; done_cyc = -1; first_wr_cyc = -1; first_wr_addr = -1;
    proto_err = 0; data_err = 0; bad_cyc = -1;
    @(negedge clock);
    start = 1'b1;
    for (int c = 1; c <= limit; c++) begin
      logic [AW-1:0] ea, eb, ec;
      logic [DW-1:0] ed;
      logic          ew, eby, edn;
      bit            live;
      int            e, ph;
      @(negedge clock);
      live = (reset_at < 0) || (c <= reset_at);
      ea = '0; eb = '0; ec = '0; ed = '0; ew = 1'b0; eby = 1'b0;
      edn = live && (c == LAST + 1);
      if (live && c <= LAST) begin
        e   = (c - 1) / P;
        ph  = (c - 1) % P;
        eby = 1'b1;
        if (ph < N) begin
          ea = AW'((e / N) * N + ph);
          eb = AW'(ph * N + (e % N));
        end
        if (ph == N + 1) begin
          ew = 1'b1;
          ec = AW'(e);
          ed = c_ref[e];
        end
      end
      if (busy !== eby || done !== edn || a_rd_addr !== ea || b_rd_addr !== eb ||
          c_wr_en !== ew || c_wr_addr !== ec) begin
        proto_err++;
        if (bad_cyc < 0) bad_cyc = c;
      end
      if (c_din !== ed) data_err++;
      if (c_wr_en === 1'b1) begin
        if (first_wr_cyc < 0) begin
          first_wr_cyc  = c;
          first_wr_addr = int'(c_wr_addr);
        end
        wr_count++;
      end
      if (done === 1'b1) begin
        done_count++;
        done_cyc = c;
      end
      start = (c == pulse_at) || (hold && c <= LAST + 2);
      reset = (c == reset_at);
    end
    reset = 1'b0;
    if (!hold) start = 1'b0;
  endtask

  function automatic int mem_mismatches(input int upto);
    int n;
    n = 0;
    for (int x = 0; x < upto; x++) if (c_mem[x] !== c_ref[x]) n++;
    return n;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    for (int x = 0; x < NE; x++) begin a_mem[x] = '0; b_mem[x] = '0; end
    repeat (3) @(negedge clock);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_wr_en", c_wr_en, 0);
    chk("reset_a_addr", a_rd_addr, 0);
    chk("reset_b_addr", b_rd_addr, 0);
    chk("reset_c_addr", c_wr_addr, 0);
    chk("reset_c_din", c_din, 0);
    reset = 1'b0;

    // Reset and start together: reset wins.
    @(negedge clock);
    reset = 1'b1; start = 1'b1;
    @(negedge clock);
    chk("rst_prio_busy", busy, 0);
    reset = 1'b0; start = 1'b0;
    @(negedge clock);
    chk("rst_prio_busy2", busy, 0);

    // Identity times a ramp.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        a_mem[r*N+c] = (r == c) ? 32'd1 : 32'd0;
        b_mem[r*N+c] = DW'(r * 8 + c);
      end
    compute_ref();
    run_mult(-1, -1, 1'b0);
    chk("ident_writes", wr_count, 64);
    chk("ident_done_cnt", done_count, 1);
    chk("ident_done_cyc", done_cyc, 641);
    chk("ident_first_wr_cyc", first_wr_cyc, 10);
    chk("ident_first_wr_addr", first_wr_addr, 0);
    chk($sformatf("ident_proto@%0d", bad_cyc), proto_err, 0);
    chk("ident_din", data_err, 0);
    chk("ident_c9", c_mem[9], 32'd9);
    chk("ident_c63", c_mem[63], 32'd63);
    chk("ident_mem", mem_mismatches(NE), 0);

    // Wrap-around of product and sum.
    for (int x = 0; x < NE; x++) begin a_mem[x] = 32'hFFFF_FFFF; b_mem[x] = 32'd2; end
    compute_ref();
    run_mult(-1, -1, 1'b0);
    begin
      int n;
      n = 0;
      for (int x = 0; x < NE; x++) if (c_mem[x] !== 32'hFFFF_FFF0) n++;
      chk("wrap_entries", n, 0);
    end
    chk($sformatf("wrap_proto@%0d", bad_cyc), proto_err, 0);

    // Random data, start pulsed mid-run.
    fill_random();
    compute_ref();
    run_mult(-1, 300, 1'b0);
    chk("busy_start_writes", wr_count, 64);
    chk("busy_start_done_cnt", done_count, 1);
    chk("busy_start_done_cyc", done_cyc, 641);
    chk($sformatf("busy_start_proto@%0d", bad_cyc), proto_err, 0);
    chk("rand1_mem", mem_mismatches(NE), 0);

    // Random data, start pulsed only during DONE.
    fill_random();
    compute_ref();
    run_mult(-1, LAST + 1, 1'b0);
    chk($sformatf("done_start_proto@%0d", bad_cyc), proto_err, 0);
    chk("done_start_writes", wr_count, 64);
    chk("rand2_mem", mem_mismatches(NE), 0);

    // Abort with reset in cycle 55.
    fill_random();
    compute_ref();
    run_mult(55, -1, 1'b0);
    chk("abort_writes", wr_count, 5);
    chk("abort_done_cnt", done_count, 0);
    chk($sformatf("abort_proto@%0d", bad_cyc), proto_err, 0);
    chk("abort_mem_first5", mem_mismatches(5), 0);

    // Full multiply after the abort.
    fill_random();
    compute_ref();
    run_mult(-1, -1, 1'b0);
    chk("after_abort_writes", wr_count, 64);
    chk($sformatf("after_abort_proto@%0d", bad_cyc), proto_err, 0);
    chk("after_abort_mem", mem_mismatches(NE), 0);

    // Start held high through DONE restarts on the first IDLE cycle.
    fill_random();
    compute_ref();
    run_mult(-1, -1, 1'b1);
    chk($sformatf("hold_proto@%0d", bad_cyc), proto_err, 0);
    chk("hold_done_cyc", done_cyc, 641);
    @(negedge clock);
    chk("hold_restart_busy", busy, 1);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    chk("hold_reset_busy", busy, 0);
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
